// File: rtl/cu_fsm.sv
// Multi-cycle control unit: INIT/FETCH/EXEC/WB sequencing with optional interrupt entry.
// Define CU_FSM_INTR_EN to enable the INTR state; otherwise intr is ignored.
module cu_fsm (
   input  logic        CLK,
   input  logic        RST,
   input  logic        intr,
   input  logic [6:0]  ir_opcode,
   input  logic [2:0]  ir_func3,
   output logic        pc_write,
   output logic        reg_write,
   output logic        mem_we2,
   output logic        mem_rden1,
   output logic        mem_rden2,
   output logic        rst_out,
   output logic        csr_we,
   output logic        int_taken,
   output logic        mret_exec,
   output logic [2:0]  state,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_WB    = 3'd3,
      ST_INTR  = 3'd4
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [2:0] F3_MRET   = 3'b000;
   localparam logic [2:0] F3_CSRRW  = 3'b001;

   state_t      state_r;
   logic [31:0] instret_r;
   logic        op_load_s;
   logic        retire_s;
   logic        intr_req_s;

`ifdef CU_FSM_INTR_EN
   assign intr_req_s = intr;
`else
   // Interrupts compiled out: the request is tied off so INTR can never be entered.
   assign intr_req_s = intr & 1'b0;
`endif

   // Load detection and the retiring-cycle condition used by both FSM and counter.
   always_comb begin
      op_load_s = (ir_opcode == OP_LOAD);
      if (state_r == ST_WB) begin
         retire_s = 1'b1;
      end else if (state_r == ST_EXEC) begin
         retire_s = !op_load_s;
      end else begin
         retire_s = 1'b0;
      end
   end

   // State register and retired-instruction counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r   <= ST_INIT;
         instret_r <= 32'd0;
      end else begin
         if (retire_s) begin
            instret_r <= instret_r + 32'd1;
         end else begin
            instret_r <= instret_r;
         end
         case (state_r)
            ST_INIT:  state_r <= ST_FETCH;
            ST_FETCH: state_r <= ST_EXEC;
            ST_EXEC: begin
               if (op_load_s) begin
                  state_r <= ST_WB;
               end else if (intr_req_s) begin
                  state_r <= ST_INTR;
               end else begin
                  state_r <= ST_FETCH;
               end
            end
            ST_WB: begin
               if (intr_req_s) begin
                  state_r <= ST_INTR;
               end else begin
                  state_r <= ST_FETCH;
               end
            end
`ifdef CU_FSM_INTR_EN
            ST_INTR:  state_r <= ST_FETCH;
`endif
            default:  state_r <= ST_INIT;
         endcase
      end
   end

   // Enable decode from current state and instruction fields.
   always_comb begin
      pc_write  = 1'b0;
      reg_write = 1'b0;
      mem_we2   = 1'b0;
      mem_rden1 = 1'b0;
      mem_rden2 = 1'b0;
      rst_out   = 1'b0;
      csr_we    = 1'b0;
      int_taken = 1'b0;
      mret_exec = 1'b0;
      case (state_r)
         ST_INIT:  rst_out   = 1'b1;
         ST_FETCH: mem_rden1 = 1'b1;
         ST_EXEC: begin
            case (ir_opcode)
               OP_LOAD: mem_rden2 = 1'b1;
               OP_REG, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
                  pc_write  = 1'b1;
                  reg_write = 1'b1;
               end
               OP_STORE: begin
                  pc_write = 1'b1;
                  mem_we2  = 1'b1;
               end
               OP_BRANCH: pc_write = 1'b1;
               OP_SYSTEM: begin
                  pc_write = 1'b1;
                  case (ir_func3)
                     F3_CSRRW: begin
                        csr_we    = 1'b1;
                        reg_write = 1'b1;
                     end
                     F3_MRET:  mret_exec = 1'b1;
                     default:  mret_exec = 1'b0;
                  endcase
               end
               default: pc_write = 1'b1;
            endcase
         end
         ST_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
         end
`ifdef CU_FSM_INTR_EN
         ST_INTR: begin
            int_taken = 1'b1;
            pc_write  = 1'b1;
         end
`endif
         default: rst_out = 1'b0;
      endcase
   end

   assign state   = state_r;
   assign instret = instret_r;

endmodule

// File: tb/tb_cu_fsm.sv
// Directed bench for cu_fsm: expected state/enables/instret are queued per cycle
// and compared against the DUT mid-cycle.
module tb_cu_fsm;

   logic        CLK = 1'b0;
   logic        RST;
   logic        intr;
   logic [6:0]  ir_opcode;
   logic [2:0]  ir_func3;
   logic        pc_write, reg_write, mem_we2, mem_rden1, mem_rden2;
   logic        rst_out, csr_we, int_taken, mret_exec;
   logic [2:0]  state;
   logic [31:0] instret;

   int total = 0;
   int bad   = 0;

   // enable vector: {pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, rst_out, csr_we, int_taken, mret_exec}
   localparam logic [8:0] E_NONE = 9'b000000000;
   localparam logic [8:0] E_PC   = 9'b100000000;
   localparam logic [8:0] E_REG  = 9'b010000000;
   localparam logic [8:0] E_WE2  = 9'b001000000;
   localparam logic [8:0] E_RD1  = 9'b000100000;
   localparam logic [8:0] E_RD2  = 9'b000010000;
   localparam logic [8:0] E_RST  = 9'b000001000;
   localparam logic [8:0] E_CSR  = 9'b000000100;
   localparam logic [8:0] E_INT  = 9'b000000010;
   localparam logic [8:0] E_MRET = 9'b000000001;

   typedef struct {
      string       tag;
      logic [2:0]  st;
      logic [8:0]  en;
      logic [31:0] ir;
   } exp_t;

   exp_t sb[$];

   cu_fsm dut (
      .CLK       (CLK),
      .RST       (RST),
      .intr      (intr),
      .ir_opcode (ir_opcode),
      .ir_func3  (ir_func3),
      .pc_write  (pc_write),
      .reg_write (reg_write),
      .mem_we2   (mem_we2),
      .mem_rden1 (mem_rden1),
      .mem_rden2 (mem_rden2),
      .rst_out   (rst_out),
      .csr_we    (csr_we),
      .int_taken (int_taken),
      .mret_exec (mret_exec),
      .state     (state),
      .instret   (instret)
   );

   always #5 CLK = ~CLK;

   // Queue an expectation for the current cycle, compare at the falling edge, then advance one cycle.
   task automatic chk(input string tag, input logic [2:0] st, input logic [8:0] en, input logic [31:0] ir);
      exp_t e;
      logic [8:0] obs_en;
      sb.push_back('{tag, st, en, ir});
      @(negedge CLK);
      e = sb.pop_front();
      obs_en = {pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, rst_out, csr_we, int_taken, mret_exec};
      total++;
      assert (state === e.st) else begin
         bad++;
         $error("FAIL %s.state observed=%0d expected=%0d", e.tag, state, e.st);
      end
      total++;
      assert (obs_en === e.en) else begin
         bad++;
         $error("FAIL %s.enables observed=%b expected=%b", e.tag, obs_en, e.en);
      end
      total++;
      assert (instret === e.ir) else begin
         bad++;
         $error("FAIL %s.instret observed=%0d expected=%0d", e.tag, instret, e.ir);
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [6:0] rw_ops [5];
      logic [31:0] n;
      rw_ops[0] = 7'b0010011;
      rw_ops[1] = 7'b0110111;
      rw_ops[2] = 7'b0010111;
      rw_ops[3] = 7'b1101111;
      rw_ops[4] = 7'b1100111;

      RST = 1'b1; intr = 1'b0; ir_opcode = 7'b0110011; ir_func3 = 3'b000;
      @(posedge CLK);
      #1;
      chk("rst_hold", 3'd0, E_RST, 32'd0);
      RST = 1'b0;
      chk("init", 3'd0, E_RST, 32'd0);

      // R-type stream
      chk("r1_fetch", 3'd1, E_RD1, 32'd0);
      chk("r1_exec", 3'd2, E_PC | E_REG, 32'd0);
      chk("r2_fetch", 3'd1, E_RD1, 32'd1);
      chk("r2_exec", 3'd2, E_PC | E_REG, 32'd1);
      chk("r3_fetch", 3'd1, E_RD1, 32'd2);
      chk("r3_exec", 3'd2, E_PC | E_REG, 32'd2);

      // load
      ir_opcode = 7'b0000011;
      chk("ld_fetch", 3'd1, E_RD1, 32'd3);
      chk("ld_exec", 3'd2, E_RD2, 32'd3);
      chk("ld_wb", 3'd3, E_PC | E_REG, 32'd3);

      // intr pulse during FETCH and load-EXEC, dropped before WB: must be ignored
      intr = 1'b1;
      chk("ldi_fetch", 3'd1, E_RD1, 32'd4);
      chk("ldi_exec", 3'd2, E_RD2, 32'd4);
      intr = 1'b0;
      chk("ldi_wb", 3'd3, E_PC | E_REG, 32'd4);

      // store with intr raised during FETCH
      ir_opcode = 7'b0100011;
      intr = 1'b1;
      chk("st_fetch", 3'd1, E_RD1, 32'd5);
      chk("st_exec", 3'd2, E_PC | E_WE2, 32'd5);
`ifdef CU_FSM_INTR_EN
      chk("st_intr", 3'd4, E_PC | E_INT, 32'd6);
      intr = 1'b0;
`else
      // intr stays high: must never enter state 4
      chk("noint_r_fetch", 3'd1, E_RD1, 32'd6);
      chk("noint_r_exec", 3'd2, E_PC | E_WE2, 32'd6);
      chk("noint_r_fetch2", 3'd1, E_RD1, 32'd7);
      chk("noint_r_exec2", 3'd2, E_PC | E_WE2, 32'd7);
      intr = 1'b0;
      chk("noint_fetch3", 3'd1, E_RD1, 32'd8);
      chk("noint_exec3", 3'd2, E_PC | E_WE2, 32'd8);
`endif
      n = instret_base();

      // branch
      ir_opcode = 7'b1100011;
      chk("br_fetch", 3'd1, E_RD1, n);
      chk("br_exec", 3'd2, E_PC, n);
      n = n + 32'd1;

      // system: MRET, CSRRW, other func3
      ir_opcode = 7'b1110011; ir_func3 = 3'b000;
      chk("mret_fetch", 3'd1, E_RD1, n);
      chk("mret_exec", 3'd2, E_PC | E_MRET, n);
      n = n + 32'd1;
      ir_func3 = 3'b001;
      chk("csr_fetch", 3'd1, E_RD1, n);
      chk("csr_exec", 3'd2, E_PC | E_REG | E_CSR, n);
      n = n + 32'd1;
      ir_func3 = 3'b010;
      chk("sys_fetch", 3'd1, E_RD1, n);
      chk("sys_exec", 3'd2, E_PC, n);
      n = n + 32'd1;

      // unrecognised opcode acts as NOP
      ir_opcode = 7'b1111111;
      chk("nop_fetch", 3'd1, E_RD1, n);
      chk("nop_exec", 3'd2, E_PC, n);
      n = n + 32'd1;

      // remaining register-writing opcodes
      for (int i = 0; i < 5; i++) begin
         ir_opcode = rw_ops[i];
         chk("rw_fetch", 3'd1, E_RD1, n);
         chk("rw_exec", 3'd2, E_PC | E_REG, n);
         n = n + 32'd1;
      end

`ifdef CU_FSM_INTR_EN
      // intr at load WB retire enters INTR; INTR exits even with intr held
      ir_opcode = 7'b0000011;
      chk("ldwb_fetch", 3'd1, E_RD1, n);
      chk("ldwb_exec", 3'd2, E_RD2, n);
      intr = 1'b1;
      chk("ldwb_wb", 3'd3, E_PC | E_REG, n);
      n = n + 32'd1;
      chk("ldwb_intr", 3'd4, E_PC | E_INT, n);
      intr = 1'b0;
`endif

      // reset asserted during WB
      ir_opcode = 7'b0000011;
      chk("rwb_fetch", 3'd1, E_RD1, n);
      chk("rwb_exec", 3'd2, E_RD2, n);
      RST = 1'b1;
      chk("rwb_wb", 3'd3, E_PC | E_REG, n);
      chk("rwb_init", 3'd0, E_RST, 32'd0);
      RST = 1'b0;
      chk("rwb_init2", 3'd0, E_RST, 32'd0);
      chk("rwb_fetch2", 3'd1, E_RD1, 32'd0);
      chk("rwb_exec2", 3'd2, E_RD2, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Instruction count after the store/interrupt segment, which differs by build.
   function automatic logic [31:0] instret_base();
`ifdef CU_FSM_INTR_EN
      return 32'd6;
`else
      return 32'd9;
`endif
   endfunction

endmodule
